rf_hazard_wb_ctrl: RTL and testbench

//  Controller for the 8x32 register file behind the decode stage.
//  - Keeps a scoreboard of registers with writes still in flight.
//  - Stalls decode on RAW and WAW hazards.
//  - Arbitrates the single RF write port between ALU and MEM writeback,
//    and drives the RF write signals (rw, dst, W1).

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/wb_port_arb.sv | 39 +++
 rtl/rf_hazard_wb_ctrl.sv | 106 ++++++++++
 tb/tb_rf_hazard_wb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and writeback request bundle
// for the register-file hazard/writeback controller.
package rf_ctrl_pkg;
  localparam int NREGS      = 8;
  localparam int AW         = 3;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 3;
  localparam int SW         = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_port_arb.sv
// 2-way MEM-priority arbiter with ALU starvation guard.
// Ports: clk, rst, alu_valid, mem_valid -> grant_alu, grant_mem.
module wb_port_arb
  import rf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_alu,
  output logic grant_mem
);

  logic [SW-1:0] starve_q, starve_d;
  logic          alu_turn;

  // ALU wins a contended cycle once it has lost STARVE_MAX in a row
  assign alu_turn  = alu_valid & (starve_q == SW'(STARVE_MAX));
  assign grant_mem = mem_valid & ~alu_turn;
  assign grant_alu = alu_valid & ~grant_mem;

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || grant_alu) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rf_hazard_wb_ctrl.sv
// Decode hazard scoreboard and RF write-port controller.
// Ports: decode request -> issue/stall; ALU/MEM wb handshakes; rf_* write port; busy; err.
module rf_hazard_wb_ctrl
  import rf_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [AW-1:0]    dec_src1,
  input  logic [AW-1:0]    dec_src2,
  input  logic             dec_use2,
  input  logic             dec_wr,
  input  logic [AW-1:0]    dec_dst,
  output logic             issue,
  output logic             stall,
  input  logic             alu_wb_valid,
  input  logic [AW-1:0]    alu_wb_dst,
  input  logic [DW-1:0]    alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             mem_wb_valid,
  input  logic [AW-1:0]    mem_wb_dst,
  input  logic [DW-1:0]    mem_wb_data,
  output logic             mem_wb_ready,
  output logic             rf_rw,
  output logic [AW-1:0]    rf_dst,
  output logic [DW-1:0]    rf_wdata,
  output logic [NREGS-1:0] busy,
  output logic             err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             rf_rw_q;
  logic [AW-1:0]    rf_dst_q;
  logic [DW-1:0]    rf_wdata_q;
  logic             err_q;

  logic    hazard;
  logic    set_en;
  logic    grant_alu, grant_mem;
  wb_req_t alu_req, mem_req, win;
  logic    err_set;

  assign alu_req = '{valid: alu_wb_valid, dst: alu_wb_dst, data: alu_wb_data};
  assign mem_req = '{valid: mem_wb_valid, dst: mem_wb_dst, data: mem_wb_data};

  // No bypass: only the registered scoreboard is consulted
  assign hazard = busy_q[dec_src1]
                | (dec_use2 & busy_q[dec_src2])
                | (dec_wr & busy_q[dec_dst]);
  assign issue  = dec_valid & ~hazard;
  assign stall  = dec_valid & ~issue;
  assign set_en = issue & dec_wr;

  wb_port_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_req.valid),
    .mem_valid (mem_req.valid),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  assign alu_wb_ready = grant_alu;
  assign mem_wb_ready = grant_mem;

  always_comb begin
    win       = grant_mem ? mem_req : alu_req;
    win.valid = grant_alu | grant_mem;
  end

  // Writeback to a register nobody is waiting on
  assign err_set = win.valid & ~busy_q[win.dst]
                 & ~(set_en & (dec_dst == win.dst));

  // Clear first so a same-edge set takes precedence
  always_comb begin
    busy_d = busy_q;
    if (rf_rw_q) busy_d[rf_dst_q] = 1'b0;
    if (set_en)  busy_d[dec_dst]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rf_rw_q    <= 1'b0;
      rf_dst_q   <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rf_rw_q <= win.valid;
      if (win.valid) begin
        rf_dst_q   <= win.dst;
        rf_wdata_q <= win.data;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign rf_rw    = rf_rw_q;
  assign rf_dst   = rf_dst_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rf_hazard_wb_ctrl.sv
// Self-checking bench for rf_hazard_wb_ctrl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_hazard_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [2:0]  dec_src1, dec_src2, dec_dst;
  logic        dec_use2, dec_wr;
  logic        issue, stall;
  logic        alu_wb_valid;
  logic [2:0]  alu_wb_dst;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [2:0]  mem_wb_dst;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        rf_rw;
  logic [2:0]  rf_dst;
  logic [31:0] rf_wdata;
  logic [7:0]  busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_hazard_wb_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_src1     (dec_src1),
    .dec_src2     (dec_src2),
    .dec_use2     (dec_use2),
    .dec_wr       (dec_wr),
    .dec_dst      (dec_dst),
    .issue        (issue),
    .stall        (stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_dst   (alu_wb_dst),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_dst   (mem_wb_dst),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .rf_rw        (rf_rw),
    .rf_dst       (rf_dst),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .err          (err)
  );

  // Behavioural reference: set of pending registers, a denial count,
  // and the one-deep write-port output.
  bit [7:0]  busy_m;
  int        starve_m;
  bit        rw_m;
  bit [2:0]  dst_m;
  bit [31:0] data_m;
  bit        err_m;

  bit        e_issue, e_galu, e_gmem, hz;
  bit [2:0]  g_dst;
  bit [31:0] g_data;
  bit [7:0]  nbusy;

  always_comb begin
    hz = busy_m[dec_src1] || (dec_use2 && busy_m[dec_src2])
      || (dec_wr && busy_m[dec_dst]);
    e_issue = dec_valid && !hz;
    if (alu_wb_valid && mem_wb_valid) begin
      e_galu = (starve_m == 3);
      e_gmem = !e_galu;
    end else begin
      e_galu = alu_wb_valid;
      e_gmem = mem_wb_valid;
    end
    g_dst  = e_gmem ? mem_wb_dst : alu_wb_dst;
    g_data = e_gmem ? mem_wb_data : alu_wb_data;
    nbusy = busy_m;
    if (rw_m) nbusy[dst_m] = 1'b0;
    if (e_issue && dec_wr) nbusy[dec_dst] = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      busy_m   <= '0;
      starve_m <= 0;
      rw_m     <= 1'b0;
      dst_m    <= '0;
      data_m   <= '0;
      err_m    <= 1'b0;
    end else begin
      busy_m <= nbusy;
      rw_m   <= e_galu || e_gmem;
      if (e_galu || e_gmem) begin
        dst_m  <= g_dst;
        data_m <= g_data;
        if (!busy_m[g_dst] && !(e_issue && dec_wr && dec_dst == g_dst))
          err_m <= 1'b1;
      end
      if (!alu_wb_valid || e_galu) starve_m <= 0;
      else if (mem_wb_valid) starve_m <= (starve_m < 3) ? starve_m + 1 : 3;
    end
  end

  task automatic idle();
    dec_valid = 0; dec_src1 = 0; dec_src2 = 0;
    dec_use2 = 0; dec_wr = 0; dec_dst = 0;
    alu_wb_valid = 0; alu_wb_dst = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_dst = 0; mem_wb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_write(input logic [2:0] d);
    idle();
    dec_valid = 1; dec_wr = 1; dec_dst = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    dec_valid = 1; dec_src1 = 1; dec_src2 = 2; dec_use2 = 1;
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL reset_issue got=%0b want=1", issue); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy got=%h want=00", busy); end
    total++; if (rf_rw !== 1'b0) begin bad++; $display("FAIL reset_rw got=%0b want=0", rf_rw); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    tick();
  endtask

  task automatic test_raw();
    dec_write(3);
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_wr_issue got=%0b want=1", issue); end
    tick();
    idle();
    dec_valid = 1; dec_src1 = 3;
    alu_wb_valid = 1; alu_wb_dst = 3; alu_wb_data = 32'hA5;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%0b want=1", stall); end
    total++; if (alu_wb_ready !== 1'b1) begin bad++; $display("FAIL raw_alu_rdy got=%0b want=1", alu_wb_ready); end
    total++; if (busy !== 8'h08) begin bad++; $display("FAIL raw_busy got=%h want=08", busy); end
    tick();
    alu_wb_valid = 0;
    #1;
    total++; if (rf_rw !== 1'b1 || rf_dst !== 3'd3) begin bad++; $display("FAIL raw_wport got=%0b/%0d want=1/3", rf_rw, rf_dst); end
    total++; if (rf_wdata !== 32'hA5) begin bad++; $display("FAIL raw_wdata got=%h want=a5", rf_wdata); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall2 got=%0b want=1", stall); end
    tick();
    #1;
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL raw_clear got=%h want=00", busy); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_reissue got=%0b want=1", issue); end
    total++; if (rf_rw !== 1'b0) begin bad++; $display("FAIL raw_rw_off got=%0b want=0", rf_rw); end
    tick();
    idle();
  endtask

  task automatic test_waw();
    dec_write(5);
    tick();
    dec_src1 = 0; dec_src2 = 1; dec_use2 = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall%0d got=%0b want=1", i, stall); end
      tick();
    end
    alu_wb_valid = 1; alu_wb_dst = 5; alu_wb_data = 32'h55;
    tick();
    alu_wb_valid = 0;
    #1;
    total++; if (stall !== 1'b1 || rf_rw !== 1'b1) begin bad++; $display("FAIL waw_wb got=%0b/%0b want=1/1", stall, rf_rw); end
    tick();
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL waw_issue got=%0b want=1", issue); end
    tick();
    idle();
    #1;
    total++; if (busy !== 8'h20) begin bad++; $display("FAIL waw_reset_busy got=%h want=20", busy); end
    mem_wb_valid = 1; mem_wb_dst = 5;
    tick();
    idle();
    tick();
    #1;
    total++; if (busy !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL waw_end got=%h/%0b want=00/0", busy, err); end
  endtask

  task automatic test_both();
    dec_write(1); tick();
    dec_write(2); tick();
    idle();
    alu_wb_valid = 1; alu_wb_dst = 1; alu_wb_data = 32'h11;
    mem_wb_valid = 1; mem_wb_dst = 2; mem_wb_data = 32'h22;
    #1;
    total++; if (mem_wb_ready !== 1'b1 || alu_wb_ready !== 1'b0) begin bad++; $display("FAIL both_grant got=%0b/%0b want=1/0", mem_wb_ready, alu_wb_ready); end
    tick();
    mem_wb_valid = 0;
    #1;
    total++; if (alu_wb_ready !== 1'b1) begin bad++; $display("FAIL both_alu got=%0b want=1", alu_wb_ready); end
    total++; if (rf_dst !== 3'd2 || rf_wdata !== 32'h22) begin bad++; $display("FAIL both_first got=%0d/%h want=2/22", rf_dst, rf_wdata); end
    tick();
    alu_wb_valid = 0;
    #1;
    total++; if (rf_rw !== 1'b1 || rf_dst !== 3'd1 || rf_wdata !== 32'h11) begin bad++; $display("FAIL both_second got=%0b/%0d/%h want=1/1/11", rf_rw, rf_dst, rf_wdata); end
    tick(); tick();
    #1;
    total++; if (busy !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL both_end got=%h/%0b want=00/0", busy, err); end
  endtask

  task automatic test_starve();
    idle();
    alu_wb_valid = 1; alu_wb_dst = 4;
    mem_wb_valid = 1; mem_wb_dst = 7;
    for (int i = 0; i < 8; i++) begin
      bit want_alu;
      want_alu = (i == 3) || (i == 7);
      #1;
      total++; if (alu_wb_ready !== want_alu || mem_wb_ready !== !want_alu) begin bad++; $display("FAIL starve_c%0d got=%0b/%0b want=%0b/%0b", i, alu_wb_ready, mem_wb_ready, want_alu, !want_alu); end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_err();
    idle();
    rst = 1; tick(); rst = 0;
    mem_wb_valid = 1; mem_wb_dst = 6; mem_wb_data = 32'h66;
    #1;
    total++; if (mem_wb_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL err_acc got=%0b/%0b want=1/0", mem_wb_ready, err); end
    tick();
    idle();
    #1;
    total++; if (rf_rw !== 1'b1 || rf_dst !== 3'd6 || rf_wdata !== 32'h66) begin bad++; $display("FAIL err_write got=%0b/%0d/%h want=1/6/66", rf_rw, rf_dst, rf_wdata); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b want=1", err); end
    tick();
    dec_write(3); tick();
    dec_write(5); tick();
    idle();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", err); end
    total++; if (busy !== 8'h28) begin bad++; $display("FAIL err_busy got=%h want=28", busy); end
    rst = 1;
    mem_wb_valid = 1; mem_wb_dst = 3; mem_wb_data = 32'h33;
    tick();
    rst = 0;
    idle();
    #1;
    total++; if (busy !== 8'h00 || rf_rw !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL err_rst got=%h/%0b/%0b want=00/0/0", busy, rf_rw, err); end
  endtask

  task automatic test_random();
    idle();
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(63) == 0);
      dec_valid    = $urandom_range(1);
      dec_src1     = 3'($urandom);
      dec_src2     = 3'($urandom);
      dec_use2     = $urandom_range(1);
      dec_wr       = $urandom_range(1);
      dec_dst      = 3'($urandom);
      alu_wb_valid = ($urandom_range(2) == 0);
      alu_wb_dst   = 3'($urandom);
      alu_wb_data  = $urandom;
      mem_wb_valid = ($urandom_range(2) == 0);
      mem_wb_dst   = 3'($urandom);
      mem_wb_data  = $urandom;
      #1;
      total++; if (issue !== e_issue || stall !== (dec_valid && !e_issue)) begin bad++; $display("FAIL rnd_issue n=%0d got=%0b/%0b want=%0b", n, issue, stall, e_issue); end
      total++; if (alu_wb_ready !== e_galu || mem_wb_ready !== e_gmem) begin bad++; $display("FAIL rnd_grant n=%0d got=%0b/%0b want=%0b/%0b", n, alu_wb_ready, mem_wb_ready, e_galu, e_gmem); end
      total++; if (busy !== busy_m || rf_rw !== rw_m || err !== err_m) begin bad++; $display("FAIL rnd_state n=%0d got=%h/%0b/%0b want=%h/%0b/%0b", n, busy, rf_rw, err, busy_m, rw_m, err_m); end
      if (rw_m) begin
        total++; if (rf_dst !== dst_m || rf_wdata !== data_m) begin bad++; $display("FAIL rnd_wport n=%0d got=%0d/%h want=%0d/%h", n, rf_dst, rf_wdata, dst_m, data_m); end
      end
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_raw();
    test_waw();
    test_both();
    test_starve();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
